// File: rtl/dual_issue_queue_pkg.sv
// Shared decode constants for the dual-issue front end: opcode/funct values
// and instruction field positions used by the queue and the control unit.
package dual_issue_queue_pkg;

  // Major opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // R-type function codes
  localparam logic [5:0] FUNCT_JR = 6'h08;

  // Architectural registers with a fixed role
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  // Instruction field slice positions
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int FN_HI  = 5;
  localparam int FN_LO  = 0;

  // True for instructions that use the single data-memory port
  function automatic logic is_mem_op(input logic [5:0] op);
    logic res;
    case (op)
      OP_LW:   res = 1'b1;
      OP_SW:   res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dual_issue_queue_checker.sv
// Protocol and occupancy assertions for the dual-issue instruction queue.
module dual_issue_queue_checker #(
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input logic          clk,
  input logic          rst,
  input logic [1:0]    in_valid,
  input logic          in_ready,
  input logic [CW-1:0] push_cnt,
  input logic [CW-1:0] count
);

  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};

  a_no_upper_only: assert property (@(posedge clk) disable iff (!rst)
    in_valid != 2'b10);

  a_count_bound: assert property (@(posedge clk) disable iff (!rst)
    count <= CNT_DEPTH);

  a_push_needs_ready: assert property (@(posedge clk) disable iff (!rst)
    (push_cnt != CNT_ZERO) |-> in_ready);

endmodule

// File: rtl/dual_issue_queue_issue_pair_check.sv
// Pairing checker: decides whether the second-oldest instruction may issue
// in the same cycle as the oldest one. Purely combinational.
module issue_pair_check
  import dual_issue_queue_pkg::*;
(
  input  logic [31:0] instr0,
  input  logic [31:0] instr1,
  output logic        pair_ok
);

  logic [5:0] op0_s;
  logic [5:0] fn0_s;
  logic [4:0] rt0_s;
  logic [4:0] rd0_s;
  logic [5:0] op1_s;
  logic [4:0] rs1_s;
  logic [4:0] rt1_s;
  logic       ctrl0_s;
  logic       mem_pair_s;
  logic [4:0] dest0_s;
  logic       uses_rt1_s;
  logic       raw_s;
  logic       unused_bits_s;

  assign op0_s = instr0[OPC_HI:OPC_LO];
  assign fn0_s = instr0[FN_HI:FN_LO];
  assign rt0_s = instr0[RT_HI:RT_LO];
  assign rd0_s = instr0[RD_HI:RD_LO];
  assign op1_s = instr1[OPC_HI:OPC_LO];
  assign rs1_s = instr1[RS_HI:RS_LO];
  assign rt1_s = instr1[RT_HI:RT_LO];

  // Fields of the pair that never influence the pairing decision
  assign unused_bits_s = ^{instr0[RS_HI:RS_LO], instr0[RD_LO-1:FN_HI+1], instr1[RD_HI:FN_LO]};

  // Slot 0 redirects fetch: the younger instruction may be on the wrong path
  always_comb begin
    ctrl0_s = 1'b0;
    case (op0_s)
      OP_J:     ctrl0_s = 1'b1;
      OP_JAL:   ctrl0_s = 1'b1;
      OP_BEQ:   ctrl0_s = 1'b1;
      OP_BNE:   ctrl0_s = 1'b1;
      OP_RTYPE: ctrl0_s = (fn0_s == FUNCT_JR);
      default:  ctrl0_s = 1'b0;
    endcase
  end

  // Only one data-memory port, so two memory ops cannot go together
  always_comb begin
    mem_pair_s = is_mem_op(op0_s) & is_mem_op(op1_s);
  end

  // Register written by slot 0; zero means nothing is written
  always_comb begin
    dest0_s = REG_ZERO;
    case (op0_s)
      OP_RTYPE: dest0_s = rd0_s;
      OP_ADDI:  dest0_s = rt0_s;
      OP_ORI:   dest0_s = rt0_s;
      OP_LW:    dest0_s = rt0_s;
      OP_JAL:   dest0_s = REG_RA;
      default:  dest0_s = REG_ZERO;
    endcase
  end

  // Does slot 1 read its rt field as a source operand
  always_comb begin
    uses_rt1_s = 1'b0;
    case (op1_s)
      OP_RTYPE: uses_rt1_s = 1'b1;
      OP_SW:    uses_rt1_s = 1'b1;
      OP_BEQ:   uses_rt1_s = 1'b1;
      OP_BNE:   uses_rt1_s = 1'b1;
      default:  uses_rt1_s = 1'b0;
    endcase
  end

  // Read-after-write between the pair and final pairing verdict
  always_comb begin
    if (dest0_s != REG_ZERO) begin
      raw_s = (dest0_s == rs1_s) | (uses_rt1_s & (dest0_s == rt1_s));
    end else begin
      raw_s = 1'b0;
    end
    pair_ok = ~(ctrl0_s | mem_pair_s | raw_s);
  end

endmodule

// File: rtl/dual_issue_queue.sv
// Circular instruction queue between superscalar fetch and dual-issue decode.
// Presents the two oldest entries as issue slots; slot 1 is withheld when the
// pair cannot legally issue together.
module dual_issue_queue
  import dual_issue_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IW    = 32,
  parameter int AW    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [1:0]             in_valid,
  input  logic [IW-1:0]          in_instr0,
  input  logic [AW-1:0]          in_pc0,
  input  logic [IW-1:0]          in_instr1,
  input  logic [AW-1:0]          in_pc1,
  output logic                   in_ready,
  input  logic                   issue_ready,
  output logic                   out_valid0,
  output logic [IW-1:0]          out_instr0,
  output logic [AW-1:0]          out_pc0,
  output logic                   out_valid1,
  output logic [IW-1:0]          out_instr1,
  output logic [AW-1:0]          out_pc1,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_TWO   = {{(CW-2){1'b0}}, 2'b10};
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_ZERO  = {PW{1'b0}};
  localparam logic [PW-1:0] PTR_ONE   = {{(PW-1){1'b0}}, 1'b1};

  logic [IW-1:0] instr_mem_r [DEPTH];
  logic [AW-1:0] pc_mem_r    [DEPTH];

  logic [PW-1:0] head_r;
  logic [PW-1:0] tail_r;
  logic [CW-1:0] count_r;

  logic [PW-1:0] slot1_idx_s;
  logic [PW-1:0] tail1_idx_s;
  logic [IW-1:0] slot0_instr_s;
  logic [IW-1:0] slot1_instr_s;
  logic [AW-1:0] slot0_pc_s;
  logic [AW-1:0] slot1_pc_s;
  logic          pair_ok_s;
  logic          has_two_s;
  logic          in_ready_s;
  logic          push_en0_s;
  logic          push_en1_s;
  logic [CW-1:0] push_cnt_s;
  logic [CW-1:0] pop_cnt_s;

  assign slot1_idx_s   = head_r + PTR_ONE;
  assign tail1_idx_s   = tail_r + PTR_ONE;
  assign slot0_instr_s = instr_mem_r[head_r];
  assign slot1_instr_s = instr_mem_r[slot1_idx_s];
  assign slot0_pc_s    = pc_mem_r[head_r];
  assign slot1_pc_s    = pc_mem_r[slot1_idx_s];
  assign count         = count_r;
  assign in_ready      = in_ready_s;

  issue_pair_check u_pair_check (
    .instr0  (slot0_instr_s),
    .instr1  (slot1_instr_s),
    .pair_ok (pair_ok_s)
  );

  // Slot presentation straight from the head of the queue (no bypass)
  always_comb begin
    out_valid0 = (count_r >= CNT_ONE);
    has_two_s  = (count_r >= CNT_TWO);
    out_valid1 = has_two_s & pair_ok_s;
    if (out_valid0) begin
      out_instr0 = slot0_instr_s;
      out_pc0    = slot0_pc_s;
    end else begin
      out_instr0 = {IW{1'b0}};
      out_pc0    = {AW{1'b0}};
    end
    if (has_two_s) begin
      out_instr1 = slot1_instr_s;
      out_pc1    = slot1_pc_s;
    end else begin
      out_instr1 = {IW{1'b0}};
      out_pc1    = {AW{1'b0}};
    end
  end

  // Push acceptance: room for a full pair, judged on the registered count only
  always_comb begin
    in_ready_s = ((CNT_DEPTH - count_r) >= CNT_TWO);
    if (in_ready_s) begin
      push_en0_s = in_valid[0];
      push_en1_s = in_valid[1];
      push_cnt_s = {{(CW-1){1'b0}}, in_valid[0]} + {{(CW-1){1'b0}}, in_valid[1]};
    end else begin
      push_en0_s = 1'b0;
      push_en1_s = 1'b0;
      push_cnt_s = CNT_ZERO;
    end
  end

  // Pop count: whatever slots are presented leave when decode accepts
  always_comb begin
    if (issue_ready) begin
      pop_cnt_s = {{(CW-1){1'b0}}, out_valid0} + {{(CW-1){1'b0}}, out_valid1};
    end else begin
      pop_cnt_s = CNT_ZERO;
    end
  end

  // Pointer and occupancy update; flush wins over same-cycle push/pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_r  <= PTR_ZERO;
      tail_r  <= PTR_ZERO;
      count_r <= CNT_ZERO;
    end else if (flush) begin
      head_r  <= PTR_ZERO;
      tail_r  <= PTR_ZERO;
      count_r <= CNT_ZERO;
    end else begin
      head_r  <= head_r + pop_cnt_s[PW-1:0];
      tail_r  <= tail_r + push_cnt_s[PW-1:0];
      count_r <= count_r + push_cnt_s - pop_cnt_s;
    end
  end

  // Entry storage; contents are only meaningful below count, so no reset
  always_ff @(posedge clk) begin
    if (push_en0_s) begin
      instr_mem_r[tail_r] <= in_instr0;
      pc_mem_r[tail_r]    <= in_pc0;
    end
    if (push_en1_s) begin
      instr_mem_r[tail1_idx_s] <= in_instr1;
      pc_mem_r[tail1_idx_s]    <= in_pc1;
    end
  end

  dual_issue_queue_checker #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_checker (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready_s),
    .push_cnt (push_cnt_s),
    .count    (count_r)
  );

endmodule

// File: tb/tb_dual_issue_queue.sv
// Self-checking bench for dual_issue_queue: a scoreboard queue mirrors the
// expected queue contents; presented slots are compared against it each cycle.
module tb_dual_issue_queue;

  localparam int DEPTH = 8;
  localparam int IW    = 32;
  localparam int AW    = 32;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic [1:0]    in_valid = 2'b00;
  logic [IW-1:0] in_instr0 = '0;
  logic [AW-1:0] in_pc0 = '0;
  logic [IW-1:0] in_instr1 = '0;
  logic [AW-1:0] in_pc1 = '0;
  logic          issue_ready = 1'b0;
  logic          in_ready;
  logic          out_valid0;
  logic [IW-1:0] out_instr0;
  logic [AW-1:0] out_pc0;
  logic          out_valid1;
  logic [IW-1:0] out_instr1;
  logic [AW-1:0] out_pc1;
  logic [CW-1:0] count;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] pc_next  = 32'h0000_1000;

  dual_issue_queue #(.DEPTH(DEPTH), .IW(IW), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_instr0   (in_instr0),
    .in_pc0      (in_pc0),
    .in_instr1   (in_instr1),
    .in_pc1      (in_pc1),
    .in_ready    (in_ready),
    .issue_ready (issue_ready),
    .out_valid0  (out_valid0),
    .out_instr0  (out_instr0),
    .out_pc0     (out_pc0),
    .out_valid1  (out_valid1),
    .out_instr1  (out_instr1),
    .out_pc1     (out_pc1),
    .count       (count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  // Reference pairing rule written from the instruction-set view
  function automatic logic ref_pair_ok(input logic [31:0] a, input logic [31:0] b);
    logic [5:0] op0;
    logic [5:0] op1;
    logic [4:0] d0;
    op0 = a[31:26];
    op1 = b[31:26];
    if (op0 == 6'h02 || op0 == 6'h03 || op0 == 6'h04 || op0 == 6'h05) return 1'b0;
    if (op0 == 6'h00 && a[5:0] == 6'h08) return 1'b0;
    if ((op0 == 6'h23 || op0 == 6'h2b) && (op1 == 6'h23 || op1 == 6'h2b)) return 1'b0;
    if (op0 == 6'h00) d0 = a[15:11];
    else if (op0 == 6'h08 || op0 == 6'h0d || op0 == 6'h23) d0 = a[20:16];
    else if (op0 == 6'h03) d0 = 5'd31;
    else d0 = 5'd0;
    if (d0 != 5'd0) begin
      if (d0 == b[25:21]) return 1'b0;
      if ((op1 == 6'h00 || op1 == 6'h2b || op1 == 6'h04 || op1 == 6'h05) && d0 == b[20:16])
        return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic exp_v1();
    if (sb.size() < 2) return 1'b0;
    return ref_pair_ok(sb[0].instr, sb[1].instr);
  endfunction

  // Compare everything the DUT presents against the scoreboard
  task automatic check_state();
    check_eq("count", 64'(count), 64'(sb.size()));
    check_eq("in_ready", 64'(in_ready), 64'(sb.size() <= DEPTH - 2));
    check_eq("out_valid0", 64'(out_valid0), 64'(sb.size() >= 1));
    check_eq("out_valid1", 64'(out_valid1), 64'(exp_v1()));
    if (sb.size() >= 1) begin
      check_eq("out_pc0", 64'(out_pc0), 64'(sb[0].pc));
      check_eq("out_instr0", 64'(out_instr0), 64'(sb[0].instr));
    end
    if (sb.size() >= 2) begin
      check_eq("out_pc1", 64'(out_pc1), 64'(sb[1].pc));
      check_eq("out_instr1", 64'(out_instr1), 64'(sb[1].instr));
    end
  endtask

  // One clock cycle: check, drive, update scoreboard at the edge. Called at negedge.
  task automatic cyc(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                     input logic ir, input logic fl);
    logic rdy;
    int   pops;
    check_state();
    rdy  = (sb.size() <= DEPTH - 2);
    pops = ir ? (int'(sb.size() >= 1) + int'(exp_v1())) : 0;
    in_valid    = v;
    in_instr0   = i0;
    in_pc0      = pc_next;
    in_instr1   = i1;
    in_pc1      = pc_next + 32'd4;
    issue_ready = ir;
    flush       = fl;
    @(posedge clk);
    if (fl) begin
      sb.delete();
    end else begin
      for (int k = 0; k < pops; k++) void'(sb.pop_front());
      if (rdy && v[0]) sb.push_back('{pc: pc_next, instr: i0});
      if (rdy && v[1]) sb.push_back('{pc: pc_next + 32'd4, instr: i1});
    end
    if (v != 2'b00) pc_next = pc_next + 32'd8;
    @(negedge clk);
    in_valid    = 2'b00;
    issue_ready = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && sb.size() > 0; k++) cyc(2'b00, 32'd0, 32'd0, 1'b1, 1'b0);
    check_eq("drain_count", 64'(count), 64'd0);
  endtask

  initial begin
    // Reset state
    #12;
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_valid0", 64'(out_valid0), 64'd0);
    check_eq("rst_valid1", 64'(out_valid1), 64'd0);
    check_eq("rst_instr0", 64'(out_instr0), 64'd0);
    check_eq("rst_pc0", 64'(out_pc0), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // 1: independent pair issues together
    cyc(2'b11, rtype(1, 2, 3, 32), itype(8, 4, 5, 1), 1'b0, 1'b0);
    check_eq("t1_count", 64'(count), 64'd2);
    check_eq("t1_valid0", 64'(out_valid0), 64'd1);
    check_eq("t1_valid1", 64'(out_valid1), 64'd1);
    cyc(2'b00, 32'd0, 32'd0, 1'b1, 1'b0);
    check_eq("t1_popped", 64'(count), 64'd0);

    // 2: RAW hazard withholds slot 1
    cyc(2'b11, rtype(1, 2, 3, 32), rtype(3, 4, 6, 34), 1'b0, 1'b0);
    check_eq("t2_valid1", 64'(out_valid1), 64'd0);
    cyc(2'b00, 32'd0, 32'd0, 1'b1, 1'b0);
    check_eq("t2_count", 64'(count), 64'd1);
    check_eq("t2_sub_slot0", 64'(out_instr0), 64'(rtype(3, 4, 6, 34)));
    drain();

    // 3: memory pair, branch in slot 0, jal followed by reader of $31
    cyc(2'b11, itype(35, 1, 2, 0), itype(43, 6, 5, 4), 1'b0, 1'b0);
    check_eq("t3_mem_valid1", 64'(out_valid1), 64'd0);
    drain();
    cyc(2'b11, itype(4, 1, 2, 3), rtype(8, 9, 10, 32), 1'b0, 1'b0);
    check_eq("t3_beq_valid1", 64'(out_valid1), 64'd0);
    drain();
    cyc(2'b11, {6'h03, 26'h40}, rtype(31, 0, 7, 32), 1'b0, 1'b0);
    check_eq("t3_jal_valid1", 64'(out_valid1), 64'd0);
    drain();

    // 4: fill to DEPTH, extra push ignored, pop a pair
    for (int k = 1; k <= 4; k++)
      cyc(2'b11, itype(8, 0, 2 * k - 1, k), itype(8, 0, 2 * k, k + 16), 1'b0, 1'b0);
    check_eq("t4_full_count", 64'(count), 64'd8);
    check_eq("t4_full_ready", 64'(in_ready), 64'd0);
    cyc(2'b11, itype(8, 0, 20, 1), itype(8, 0, 21, 2), 1'b0, 1'b0);
    check_eq("t4_ignored", 64'(count), 64'd8);
    cyc(2'b00, 32'd0, 32'd0, 1'b1, 1'b0);
    check_eq("t4_pop_count", 64'(count), 64'd6);
    check_eq("t4_pop_ready", 64'(in_ready), 64'd1);
    drain();

    // 5: walk tail to 7, then double pushes that wrap through index 0
    cyc(2'b11, itype(8, 0, 1, 5), itype(8, 0, 2, 6), 1'b0, 1'b0);
    cyc(2'b11, itype(8, 0, 3, 7), itype(8, 0, 4, 8), 1'b0, 1'b0);
    drain();
    cyc(2'b01, itype(13, 0, 9, 9), 32'd0, 1'b0, 1'b0);
    drain();
    cyc(2'b11, itype(8, 0, 11, 11), itype(8, 0, 12, 12), 1'b0, 1'b0);
    cyc(2'b11, itype(8, 0, 13, 13), itype(13, 0, 14, 14), 1'b0, 1'b0);
    check_eq("t5_wrap_count", 64'(count), 64'd4);
    drain();

    // 6: flush beats push and pop; then reset mid-stream
    cyc(2'b11, itype(8, 0, 1, 1), itype(8, 0, 2, 2), 1'b0, 1'b0);
    cyc(2'b11, itype(8, 0, 3, 3), itype(8, 0, 4, 4), 1'b0, 1'b0);
    cyc(2'b01, itype(8, 0, 5, 5), 32'd0, 1'b0, 1'b0);
    check_eq("t6_pre_count", 64'(count), 64'd5);
    cyc(2'b11, itype(8, 0, 6, 6), itype(8, 0, 7, 7), 1'b1, 1'b1);
    check_eq("t6_flush_count", 64'(count), 64'd0);
    check_eq("t6_flush_valid0", 64'(out_valid0), 64'd0);
    cyc(2'b00, 32'd0, 32'd0, 1'b1, 1'b0);
    cyc(2'b11, itype(8, 0, 8, 8), itype(8, 0, 9, 9), 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check_eq("mrst_count", 64'(count), 64'd0);
    check_eq("mrst_valid0", 64'(out_valid0), 64'd0);
    check_eq("mrst_valid1", 64'(out_valid1), 64'd0);
    check_eq("mrst_instr0", 64'(out_instr0), 64'd0);
    check_eq("mrst_pc0", 64'(out_pc0), 64'd0);
    check_eq("mrst_ready", 64'(in_ready), 64'd1);
    sb.delete();
    #1;
    rst = 1'b1;
    @(negedge clk);
    cyc(2'b11, rtype(1, 2, 3, 32), itype(8, 4, 5, 1), 1'b0, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
